aq_mp_axim_ratio_gen: RTL and testbench



---
 rtl/aq_mp_axim_ratio_gen.sv | 165 ++++++++++++++++
 tb/tb_aq_mp_axim_ratio_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/aq_mp_axim_ratio_gen.sv
// ---------------------------------------------------------------------------
// aq_mp_axim_ratio_gen
//
// Purpose:
//   Generates the AXI-master clock-enable pulse train (axim_clk_en) from the
//   CPU clock. One pulse is issued every ratio_cur+1 CPU cycles. The ratio
//   can be changed at runtime through a request/acknowledge handshake. A new
//   ratio is applied only while the bus interface reports idle, and only on
//   the edge that ends an AXI period, so no partial AXI cycle is produced.
//
// Optional feature (macro AQ_AXIM_RATIO_TMO_EN):
//   When defined, the wait for bus idle is bounded by a TMO_W-bit counter.
//   Expiry abandons the change with a one-cycle ratio_err pulse. When not
//   defined, the wait is unbounded and ratio_err is tied to 0.
//
// Ports:
//   forever_cpuclk    in   free-running CPU clock, rising edge
//   cpurst_b          in   synchronous active-low reset
//   pad_yy_scan_mode  in   scan mode, forces axim_clk_en high
//   ratio_req         in   one-cycle ratio change request
//   ratio_req_val     in   requested ratio (sampled with ratio_req when idle)
//   biu_ratio_idle    in   AXI master has no outstanding transactions
//   axim_clk_en       out  AXI clock-enable pulse (registered, scan-forced)
//   ratio_cur         out  currently applied ratio
//   ratio_busy        out  a ratio change is in progress
//   ratio_ack         out  one-cycle pulse, change applied
//   ratio_err         out  one-cycle pulse, change aborted on timeout
//   ratio_fsm_st      out  debug view of the change-handshake state
//
// Handshake: a request is accepted only when ratio_busy is 0 at the edge
// where ratio_req is 1; requests while busy are dropped. Every accepted
// request ends with exactly one ratio_ack (or ratio_err on timeout).
// ---------------------------------------------------------------------------
module aq_mp_axim_ratio_gen #(
    parameter int          RATIO_W    = 3,
    parameter int unsigned DFLT_RATIO = 1,
    parameter int          TMO_W      = 8
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst_b,
    input  logic               pad_yy_scan_mode,
    input  logic               ratio_req,
    input  logic [RATIO_W-1:0] ratio_req_val,
    input  logic               biu_ratio_idle,
    output logic               axim_clk_en,
    output logic [RATIO_W-1:0] ratio_cur,
    output logic               ratio_busy,
    output logic               ratio_ack,
    output logic               ratio_err,
    output logic [1:0]         ratio_fsm_st
);

    localparam logic [RATIO_W-1:0] DFLT_R = RATIO_W'(DFLT_RATIO);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_WAIT_EDGE = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [RATIO_W-1:0] cnt;
    logic [RATIO_W-1:0] new_ratio;
    logic               clk_en_q;
    logic               cnt_wrap;
    logic               do_switch;

    // The wrap is a compare against ratio_cur, so the all-ones ratio gives a
    // full 2^RATIO_W period without relying on counter overflow.
    assign cnt_wrap = (cnt == ratio_cur);

`ifdef AQ_AXIM_RATIO_TMO_EN
    // Abort on the edge at which the wait counter would reach all-ones.
    localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_abort;
    logic             err_q;
`endif

    always_comb begin
        state_nxt = state;
        do_switch = 1'b0;
`ifdef AQ_AXIM_RATIO_TMO_EN
        tmo_abort = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (ratio_req) state_nxt = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (biu_ratio_idle) begin
                    state_nxt = ST_WAIT_EDGE;
                end
`ifdef AQ_AXIM_RATIO_TMO_EN
                else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = ST_IDLE;
                    tmo_abort = 1'b1;
                end
`endif
            end
            ST_WAIT_EDGE: begin
                // Idle must still hold on the switching edge itself.
                if (!biu_ratio_idle) begin
                    state_nxt = ST_WAIT_IDLE;
                end else if (cnt_wrap) begin
                    do_switch = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ratio_cur <= DFLT_R;
            new_ratio <= '0;
            clk_en_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_wrap ? '0 : cnt + RATIO_W'(1);
            // The pulse for the current period is still issued on the
            // switching edge; the new ratio governs the following period.
            clk_en_q <= cnt_wrap;
            if (do_switch) ratio_cur <= new_ratio;
            if ((state == ST_IDLE) && ratio_req) new_ratio <= ratio_req_val;
        end
    end

`ifdef AQ_AXIM_RATIO_TMO_EN
    // Counts only while remaining in WAIT_IDLE; held at zero elsewhere so a
    // fall-back from WAIT_EDGE restarts the wait from zero.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if ((state == ST_WAIT_IDLE) && (state_nxt == ST_WAIT_IDLE))
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            else
                tmo_cnt <= '0;
            err_q <= tmo_abort;
        end
    end

    assign ratio_err = err_q;
`else
    assign ratio_err = 1'b0;
`endif

    assign axim_clk_en  = clk_en_q | pad_yy_scan_mode;
    assign ratio_busy   = (state != ST_IDLE);
    assign ratio_ack    = (state == ST_DONE);
    assign ratio_fsm_st = state;

endmodule

// File: tb/tb_aq_mp_axim_ratio_gen.sv
// ---------------------------------------------------------------------------
// tb_aq_mp_axim_ratio_gen
//
// Self-checking bench for aq_mp_axim_ratio_gen (default build). A reference
// model tracks absolute edge numbers: the next pulse edge is scheduled as
// "last pulse edge + ratio + 1", and a ratio change is applied at the first
// scheduled pulse edge after idle has been seen and kept.
// ---------------------------------------------------------------------------
module tb_aq_mp_axim_ratio_gen;

    localparam int RATIO_W = 3;
    localparam int DFLT    = 1;

    // ---------------- clock / reset block ----------------
    logic forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    logic               cpurst_b = 1'b0;
    logic               pad_yy_scan_mode = 1'b0;
    logic               ratio_req = 1'b0;
    logic [RATIO_W-1:0] ratio_req_val = '0;
    logic               biu_ratio_idle = 1'b0;
    logic               axim_clk_en;
    logic [RATIO_W-1:0] ratio_cur;
    logic               ratio_busy;
    logic               ratio_ack;
    logic               ratio_err;
    logic [1:0]         ratio_fsm_st;

    aq_mp_axim_ratio_gen #(
        .RATIO_W   (RATIO_W),
        .DFLT_RATIO(DFLT),
        .TMO_W     (8)
    ) dut (
        .forever_cpuclk  (forever_cpuclk),
        .cpurst_b        (cpurst_b),
        .pad_yy_scan_mode(pad_yy_scan_mode),
        .ratio_req       (ratio_req),
        .ratio_req_val   (ratio_req_val),
        .biu_ratio_idle  (biu_ratio_idle),
        .axim_clk_en     (axim_clk_en),
        .ratio_cur       (ratio_cur),
        .ratio_busy      (ratio_busy),
        .ratio_ack       (ratio_ack),
        .ratio_err       (ratio_err),
        .ratio_fsm_st    (ratio_fsm_st)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    int n_ack = 0;
    logic [RATIO_W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    int m_n     = 0;    // edges since reset released
    int m_next  = DFLT + 1;
    int m_ratio = DFLT;
    int m_pend  = 0;
    int m_phase = 0;    // 0 none, 1 awaiting idle, 2 idle held, 3 applied
    bit m_pulse = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst_b, input bit req, input int val, input bit idle);
        if (!rst_b) begin
            m_n = 0; m_next = DFLT + 1; m_ratio = DFLT; m_phase = 0; m_pulse = 0;
            exp_q.delete();
        end else begin
            m_n++;
            m_pulse = (m_n == m_next);
            case (m_phase)
                0: if (req) begin
                    m_phase = 1; m_pend = val;
                    exp_q.push_back(RATIO_W'(val));
                end
                1: if (idle) m_phase = 2;
                2: if (!idle) m_phase = 1;
                   else if (m_pulse) begin m_ratio = m_pend; m_phase = 3; end
                default: m_phase = 0;
            endcase
            if (m_pulse) m_next = m_n + m_ratio + 1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit rst_b, input bit scan, input bit req, input int val, input bit idle);
        logic [RATIO_W-1:0] e;
        cpurst_b         = rst_b;
        pad_yy_scan_mode = scan;
        ratio_req        = req;
        ratio_req_val    = RATIO_W'(val);
        biu_ratio_idle   = idle;
        @(posedge forever_cpuclk);
        model_edge(rst_b, req, val, idle);
        #1;
        check("axim_clk_en", int'(axim_clk_en), int'(m_pulse | scan));
        check("ratio_cur", int'(ratio_cur), m_ratio);
        check("ratio_busy", int'(ratio_busy), int'(m_phase != 0));
        check("ratio_ack", int'(ratio_ack), int'(m_phase == 3));
        check("ratio_err", int'(ratio_err), 0);
        if (ratio_ack) begin
            n_ack++;
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("ack_ratio", int'(ratio_cur), int'(e));
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rst_b; bit scan; bit req; int val; bit idle;
        bit en; int cur; bit busy; bit ack;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int acks0;
        // rst scan req val idle | en cur busy ack
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 1, 1, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[4]  = '{1, 0, 0, 0, 0, 1, 1, 0, 0};
        tbl[5]  = '{1, 0, 1, 3, 1, 0, 1, 1, 0};
        tbl[6]  = '{1, 0, 0, 0, 1, 1, 1, 1, 0};
        tbl[7]  = '{1, 0, 0, 0, 1, 0, 1, 1, 0};
        tbl[8]  = '{1, 0, 0, 0, 1, 1, 3, 1, 1};
        tbl[9]  = '{1, 0, 0, 0, 1, 0, 3, 0, 0};
        tbl[10] = '{1, 0, 0, 0, 1, 0, 3, 0, 0};
        tbl[11] = '{1, 0, 0, 0, 1, 0, 3, 0, 0};
        tbl[12] = '{1, 0, 0, 0, 1, 1, 3, 0, 0};
        tbl[13] = '{1, 0, 0, 0, 1, 0, 3, 0, 0};
        tbl[14] = '{1, 1, 0, 0, 1, 1, 3, 0, 0};
        tbl[15] = '{1, 0, 0, 0, 1, 0, 3, 0, 0};
        tbl[16] = '{1, 0, 0, 0, 1, 1, 3, 0, 0};

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rst_b, tbl[i].scan, tbl[i].req, tbl[i].val, tbl[i].idle);
            check("tbl_en", int'(axim_clk_en), int'(tbl[i].en));
            check("tbl_cur", int'(ratio_cur), tbl[i].cur);
            check("tbl_busy", int'(ratio_busy), int'(tbl[i].busy));
            check("tbl_ack", int'(ratio_ack), int'(tbl[i].ack));
        end

        // Ratio 0 requested while the bus stays busy for 20 cycles.
        acks0 = n_ack;
        step(1, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);
        check("held_cur", int'(ratio_cur), 3);
        check("held_busy", int'(ratio_busy), 1);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 1);
        check("r0_acks", n_ack - acks0, 1);
        check("r0_cur", int'(ratio_cur), 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 1);
            check("r0_const_en", int'(axim_clk_en), 1);
        end

        // Second request during busy is dropped.
        acks0 = n_ack;
        step(1, 0, 1, 2, 1);
        step(1, 0, 1, 5, 1);
        for (int i = 0; i < 15; i++) step(1, 0, 0, 0, 1);
        check("busy_drop_cur", int'(ratio_cur), 2);
        check("busy_drop_acks", n_ack - acks0, 1);

        // Reset while waiting for the period edge.
        acks0 = n_ack;
        step(1, 0, 1, 7, 1);
        step(1, 0, 0, 0, 1);
        check("pre_rst_busy", int'(ratio_busy), 1);
        step(0, 0, 0, 0, 1);
        check("rst_cur", int'(ratio_cur), DFLT);
        check("rst_busy", int'(ratio_busy), 0);
        check("rst_ack", int'(ratio_ack), 0);
        check("rst_en", int'(axim_clk_en), 0);
        step(1, 0, 0, 0, 1);
        check("restart_e1", int'(axim_clk_en), 0);
        step(1, 0, 0, 0, 1);
        check("restart_e2", int'(axim_clk_en), 1);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1);
        check("rst_no_ack", n_ack - acks0, 0);
        check("rst_cur_kept", int'(ratio_cur), DFLT);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 399) != 0,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 7)),
                 $urandom_range(0, 3) != 0);
        end

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
